// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux and load alignment/extension.
// Define WB_RETIRE_CNT_EN to add the 64-bit retire_count output.
module mem_wb_stage #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int RegNumWidth = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AddrWidth-1:0]   mem_pc,
    input  logic [RegNumWidth-1:0] mem_rd,
    input  logic                   mem_reg_we,
    input  logic [1:0]             mem_wb_sel,
    input  logic [DataWidth-1:0]   mem_alu_result,
    input  logic [DataWidth-1:0]   mem_imm,
    input  logic [2:0]             mem_funct3,
    input  logic                   dmem_rvalid,
    input  logic [DataWidth-1:0]   dmem_rdata,
    output logic                   regWriteEnable,
    output logic [RegNumWidth-1:0] regWriteNum,
    output logic [DataWidth-1:0]   regWriteData,
    output logic                   wb_valid,
    output logic [AddrWidth-1:0]   wb_pc
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]            retire_count
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} stateT;

    stateT                  state;
    logic [AddrWidth-1:0]   pendPc;
    logic [RegNumWidth-1:0] pendRd;
    logic                   pendWe;
    logic [2:0]             pendFunct3;
    logic [1:0]             pendLane;

    logic                   accept;
    logic [AddrWidth-1:0]   pcPlus4;
    logic [DataWidth-1:0]   selData;

    function automatic logic [DataWidth-1:0] extendLoad(
        input logic [2:0]           funct3,
        input logic [1:0]           lane,
        input logic [DataWidth-1:0] word
    );
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        byteVal = 8'(word >> {lane, 3'b000});
        halfVal = 16'(word >> {lane[1], 4'b0000});
        case (funct3)
            3'b000:  extendLoad = {{(DataWidth-8){byteVal[7]}}, byteVal};
            3'b100:  extendLoad = {{(DataWidth-8){1'b0}}, byteVal};
            3'b001:  extendLoad = {{(DataWidth-16){halfVal[15]}}, halfVal};
            3'b101:  extendLoad = {{(DataWidth-16){1'b0}}, halfVal};
            default: extendLoad = word;
        endcase
    endfunction

    assign mem_ready = (state == IDLE) && !reset;
    assign accept    = mem_valid && mem_ready && !flush;
    assign pcPlus4   = mem_pc + AddrWidth'(4);

    always_comb begin
        selData = mem_alu_result;
        case (mem_wb_sel)
            2'b00: selData = mem_alu_result;
            2'b01: selData = extendLoad(mem_funct3, mem_alu_result[1:0], dmem_rdata);
            2'b10: selData = DataWidth'(pcPlus4);
            2'b11: selData = mem_imm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            regWriteEnable <= 1'b0;
            regWriteNum    <= '0;
            regWriteData   <= '0;
            wb_valid       <= 1'b0;
            wb_pc          <= '0;
            pendPc         <= '0;
            pendRd         <= '0;
            pendWe         <= 1'b0;
            pendFunct3     <= '0;
            pendLane       <= '0;
        end else begin
            wb_valid       <= 1'b0;
            regWriteEnable <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (mem_wb_sel == 2'b01 && !dmem_rvalid) begin
                            pendPc     <= mem_pc;
                            pendRd     <= mem_rd;
                            pendWe     <= mem_reg_we;
                            pendFunct3 <= mem_funct3;
                            pendLane   <= mem_alu_result[1:0];
                            state      <= WAIT_LOAD;
                        end else begin
                            wb_valid       <= 1'b1;
                            regWriteEnable <= mem_reg_we && (mem_rd != '0);
                            regWriteNum    <= mem_rd;
                            regWriteData   <= selData;
                            wb_pc          <= mem_pc;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // flush takes priority over a response arriving in the same cycle
                    if (flush) begin
                        state <= IDLE;
                    end else if (dmem_rvalid) begin
                        wb_valid       <= 1'b1;
                        regWriteEnable <= pendWe && (pendRd != '0);
                        regWriteNum    <= pendRd;
                        regWriteData   <= extendLoad(pendFunct3, pendLane, dmem_rdata);
                        wb_pc          <= pendPc;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= '0;
        end else if (wb_valid) begin
            retire_count <= retire_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a transaction-level model checked every
// cycle, plus literal expectations on the documented scenarios.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_pc;
    logic [4:0]  mem_rd;
    logic        mem_reg_we;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_imm;
    logic [2:0]  mem_funct3;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        regWriteEnable;
    logic [4:0]  regWriteNum;
    logic [31:0] regWriteData;
    logic        wb_valid;
    logic [31:0] wb_pc;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    int errors = 0;
    int checks = 0;
    logic started = 1'b0;

    mem_wb_stage #(.AddrWidth(32), .DataWidth(32), .RegNumWidth(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
        .mem_imm(mem_imm), .mem_funct3(mem_funct3),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .regWriteEnable(regWriteEnable), .regWriteNum(regWriteNum),
        .regWriteData(regWriteData), .wb_valid(wb_valid), .wb_pc(wb_pc)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: a load either completes immediately or sits in a one-entry pending slot.
    logic        mBusy;
    logic [31:0] mPendPc, mPendAddr;
    logic [4:0]  mPendRd;
    logic        mPendWe;
    logic [2:0]  mPendF3;
    logic        mValid, mWe;
    logic [4:0]  mNum;
    logic [31:0] mData, mPc;
    logic [63:0] mCnt;

    function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
        int unsigned b, h;
        b = (word / (32'd1 << (8 * addr[1:0]))) % 256;
        h = (word / (32'd1 << (16 * addr[1]))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                          input logic [31:0] value);
        mValid = 1'b1;
        mWe    = we && (rd != 0);
        mNum   = rd;
        mData  = value;
        mPc    = pc;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mBusy = 0; mValid = 0; mWe = 0; mNum = 0; mData = 0; mPc = 0; mCnt = 0;
        end else begin
            if (mValid) mCnt = mCnt + 1;
            mValid = 0;
            mWe    = 0;
            if (mBusy) begin
                if (flush) mBusy = 0;
                else if (dmem_rvalid) begin
                    retire(mPendPc, mPendRd, mPendWe, loadValue(mPendF3, mPendAddr, dmem_rdata));
                    mBusy = 0;
                end
            end else if (mem_valid && !flush) begin
                if (mem_wb_sel == 2'b01 && !dmem_rvalid) begin
                    mBusy = 1; mPendPc = mem_pc; mPendRd = mem_rd; mPendWe = mem_reg_we;
                    mPendF3 = mem_funct3; mPendAddr = mem_alu_result;
                end else begin
                    case (mem_wb_sel)
                        2'b00: retire(mem_pc, mem_rd, mem_reg_we, mem_alu_result);
                        2'b01: retire(mem_pc, mem_rd, mem_reg_we,
                                      loadValue(mem_funct3, mem_alu_result, dmem_rdata));
                        2'b10: retire(mem_pc, mem_rd, mem_reg_we, mem_pc + 32'd4);
                        2'b11: retire(mem_pc, mem_rd, mem_reg_we, mem_imm);
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc.wb_valid", wb_valid, mValid);
            chk("cyc.we", regWriteEnable, mWe);
            chk("cyc.num", regWriteNum, mNum);
            chk("cyc.data", regWriteData, mData);
            chk("cyc.pc", wb_pc, mPc);
            chk("cyc.ready", mem_ready, !mBusy && !reset);
`ifdef WB_RETIRE_CNT_EN
            chk("cyc.count", retire_count, mCnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flush = 0; mem_valid = 0; mem_pc = 0; mem_rd = 0; mem_reg_we = 0; mem_wb_sel = 0;
        mem_alu_result = 0; mem_imm = 0; mem_funct3 = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic aluOp(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                         input logic [31:0] pc, input logic [31:0] val);
        clr();
        mem_valid = 1; mem_wb_sel = sel; mem_rd = rd; mem_reg_we = we; mem_pc = pc;
        mem_alu_result = val; mem_imm = val;
        tick();
    endtask

    task automatic loadOp(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] pc, input logic rv, input logic [31:0] word);
        clr();
        mem_valid = 1; mem_wb_sel = 2'b01; mem_funct3 = f3; mem_alu_result = addr;
        mem_rd = rd; mem_reg_we = 1; mem_pc = pc; dmem_rvalid = rv; dmem_rdata = word;
        tick();
    endtask

    task automatic idle(input logic rv, input logic [31:0] word, input logic fl);
        clr();
        dmem_rvalid = rv; dmem_rdata = word; flush = fl;
        tick();
    endtask

    task automatic expOut(input string n, input logic v, input logic we,
                          input logic [4:0] num, input logic [31:0] data);
        chk({n, ".valid"}, wb_valid, v);
        chk({n, ".we"}, regWriteEnable, we);
        chk({n, ".num"}, regWriteNum, num);
        chk({n, ".data"}, regWriteData, data);
    endtask

    initial begin
        clr();
        reset = 1;
        tick();
        started = 1;
        tick();
        expOut("reset", 0, 0, 0, 0);
        chk("reset.pc", wb_pc, 0);
        chk("reset.ready", mem_ready, 0);
        reset = 0;
        #1;
        chk("ready_after_reset", mem_ready, 1);

        aluOp(2'b00, 5, 1, 32'h100, 32'h1234);
        expOut("alu", 1, 1, 5, 32'h1234);
        chk("alu.pc", wb_pc, 32'h100);
        idle(0, 0, 0);
        expOut("alu_next", 0, 0, 5, 32'h1234);

        aluOp(2'b10, 1, 1, 32'hFFFF_FFFC, 32'h5555);
        expOut("jal_wrap", 1, 1, 1, 32'h0);
        aluOp(2'b11, 3, 1, 32'h200, 32'hABCD_E000);
        expOut("lui", 1, 1, 3, 32'hABCD_E000);

        loadOp(3'd0, 32'h1003, 7, 32'h300, 0, 0);
        expOut("lb_accept", 0, 0, 3, 32'hABCD_E000);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) aluOp(2'b00, 9, 1, 32'h400, 32'h99);
            else        idle(0, 0, 0);
            chk("lb_stall.ready", mem_ready, 0);
            chk("lb_stall.valid", wb_valid, 0);
        end
        idle(1, 32'h80FF_0000, 0);
        expOut("lb_wait", 1, 1, 7, 32'hFFFF_FF80);
        chk("lb_wait.pc", wb_pc, 32'h300);
        chk("lb_wait.ready", mem_ready, 1);

        loadOp(3'd4, 32'h2000, 8, 32'h310, 1, 32'h8001_7F80);
        expOut("lbu0", 1, 1, 8, 32'h0000_0080);
        loadOp(3'd1, 32'h2002, 9, 32'h314, 1, 32'h8001_7F80);
        expOut("lh2", 1, 1, 9, 32'hFFFF_8001);
        loadOp(3'd5, 32'h2002, 10, 32'h318, 1, 32'h8001_7F80);
        expOut("lhu2", 1, 1, 10, 32'h0000_8001);
        loadOp(3'd0, 32'h2001, 11, 32'h31C, 1, 32'h8001_7F80);
        expOut("lb1", 1, 1, 11, 32'h0000_007F);
        loadOp(3'd2, 32'h2003, 12, 32'h320, 1, 32'h8001_7F80);
        expOut("lw", 1, 1, 12, 32'h8001_7F80);
        loadOp(3'd3, 32'h2000, 13, 32'h324, 1, 32'h8001_7F80);
        expOut("f3_other", 1, 1, 13, 32'h8001_7F80);
        loadOp(3'd1, 32'h2003, 14, 32'h328, 1, 32'h8001_7F80);
        expOut("lh3", 1, 1, 14, 32'hFFFF_8001);
        loadOp(3'd0, 32'h2002, 15, 32'h32C, 1, 32'h8001_7F80);
        expOut("lb2", 1, 1, 15, 32'h0000_0001);

        aluOp(2'b00, 0, 1, 32'h500, 32'h77);
        expOut("rd0", 1, 0, 0, 32'h77);

        clr();
        mem_valid = 1; mem_rd = 2; mem_reg_we = 1; mem_alu_result = 32'h66; flush = 1;
        tick();
        expOut("flush_idle", 0, 0, 0, 32'h77);

        loadOp(3'd2, 32'h3000, 6, 32'h600, 0, 0);
        idle(1, 32'hDEAD_BEEF, 1);
        expOut("flush_wait", 0, 0, 0, 32'h77);
        chk("flush_wait.ready", mem_ready, 1);
        idle(1, 32'hDEAD_BEEF, 0);
        expOut("after_flush", 0, 0, 0, 32'h77);

        loadOp(3'd2, 32'h3004, 4, 32'h700, 0, 0);
        clr();
        reset = 1;
        tick();
        reset = 0;
        idle(1, 32'h1234_5678, 0);
        expOut("reset_load", 0, 0, 0, 0);
        chk("reset_load.pc", wb_pc, 0);

        for (int i = 0; i < 4; i++) begin
            aluOp(2'b00, 5'(10 + i), 1, 32'h800 + 32'(4 * i), 32'h1000 + 32'(i));
            expOut("b2b", 1, 1, 5'(10 + i), 32'h1000 + 32'(i));
            chk("b2b.pc", wb_pc, 32'h800 + 32'(4 * i));
        end
        idle(0, 0, 0);
        idle(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback mux and load-data alignment/extension for the 5-stage RISC-V pipeline.
- Accepts one instruction per cycle from the MEM stage and waits on the data-memory read response for loads.
- Drives the register file write port (regWriteEnable/regWriteNum/regWriteData) from registers, so the write is stable for the full cycle before the register file's negedge write.

Parameters:
- AddrWidth, 32, PC/address width
- DataWidth, 32, register/data width
- RegNumWidth, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard in-flight/accepting instruction
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  stage can accept (combinational; low = stall upstream)
- mem_pc  in  AddrWidth  instruction PC
- mem_rd  in  RegNumWidth  destination register
- mem_reg_we  in  1  instruction writes rd
- mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate
- mem_alu_result  in  DataWidth  ALU result (also load address)
- mem_imm  in  DataWidth  immediate (LUI)
- mem_funct3  in  3  load type
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DataWidth  aligned 32-bit word from data memory
- regWriteEnable  out  1  register file write enable
- regWriteNum  out  RegNumWidth  register file write index
- regWriteData  out  DataWidth  register file write data
- wb_valid  out  1  instruction retired this cycle
- wb_pc  out  AddrWidth  PC of retiring instruction

Behaviour:
- Reset: state IDLE; regWriteEnable=0, regWriteNum=0, regWriteData=0, wb_valid=0, wb_pc=0; pending load discarded.
- States: IDLE, WAIT_LOAD.
- mem_ready = (state==IDLE) && !reset. Acceptance = mem_valid && mem_ready && !flush.
- IDLE, accept, wb_sel!=01: next cycle wb_valid=1, regWriteEnable = mem_reg_we && (mem_rd!=0), regWriteNum=mem_rd, regWriteData=selected value. Latency 1 cycle; throughput 1/cycle.
- Selected value:
  - 00: alu_result
  - 10: mem_pc+4, modulo 2^AddrWidth (0xFFFFFFFC -> 0x00000000)
  - 11: imm
- IDLE, accept load with dmem_rvalid=1 in the same cycle: completes like a non-load (latency 1).
- IDLE, accept load with dmem_rvalid=0: capture pc/rd/we/funct3/addr[1:0]; go to WAIT_LOAD; mem_ready=0.
- WAIT_LOAD, dmem_rvalid=1: next cycle writeback output with the extended data; return to IDLE. dmem_rvalid is ignored in IDLE when no load is being accepted.
- Load extension (byte lane = alu_result[1:0]):
  - 000 LB: sign-extend byte[lane]
  - 100 LBU: zero-extend byte[lane]
  - 001 LH: sign-extend half[alu_result[1]]
  - 101 LHU: zero-extend half[alu_result[1]]
  - 010 LW: full word
  - any other funct3: treated as LW
  - Address bit 0 is ignored for halfwords; bits [1:0] are ignored for words (no misalignment trap).
- Outputs not retiring in a cycle: wb_valid=0 and regWriteEnable=0. regWriteNum, regWriteData and wb_pc hold their last values.
- rd==0 with reg_we=1: wb_valid=1, regWriteEnable=0.
- flush:
  - In IDLE, blocks acceptance that cycle.
  - In WAIT_LOAD, returns to IDLE with no writeback.
  - flush and dmem_rvalid in the same cycle: flush wins.
  - flush does not cancel a writeback already registered.
- reset mid-load: same as reset; a later dmem_rvalid is ignored.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: adds output retire_count (64 bits), reset to 0, incremented by 1 in every cycle wb_valid=1, wrapping at 2^64.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- ALU writeback: accept wb_sel=00, rd=5, alu=0x1234, we=1 -> next cycle regWriteEnable=1, regWriteNum=5, regWriteData=0x1234, wb_valid=1; the following cycle regWriteEnable=0.
- JAL link wrap: wb_sel=10, pc=0xFFFFFFFC, rd=1 -> regWriteData=0x00000000.
- Load wait: LB, addr=...3, rd=7, dmem_rvalid held low 3 cycles, then rdata=0x80FF_0000 -> mem_ready=0 for 3 cycles; one cycle after rvalid, regWriteData=0xFFFFFF80, regWriteNum=7; then mem_ready=1.
- Extension matrix: rdata=0x8001_7F80 with LBU@0 -> 0x80, LH@2 -> 0xFFFF8001, LHU@2 -> 0x8001, LB@1 -> 0x7F, LW -> 0x80017F80.
- rd=0 and flush: ALU op with rd=0, we=1 -> wb_valid=1, regWriteEnable=0. Load pending, then flush and dmem_rvalid asserted together -> no write, state IDLE, mem_ready=1 next cycle.
- Reset mid-load: reset asserted in WAIT_LOAD, then dmem_rvalid=1 -> all outputs 0, no write. Back-to-back ALU ops at 1/cycle afterwards each write in order.
